maxpool_sequencer: RTL and testbench

Drives the binary 2-D max-pooling accumulator from a raster-order 1-bit feature-map stream. It generates the accumulator's address, write-enable and read-enable, and captures each pooled output row when it is read out. Each pooled row is presented downstream as one OUT_W-bit word under a valid/ready handshake. It sits between a binary conv layer output stream and the next layer's input buffer, and owns all pooling sequencing.

---
 rtl/maxpool_sequencer_if.sv | 29 ++
 rtl/maxpool_sequencer.sv | 118 +++++++++++
 tb/tb_maxpool_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/maxpool_sequencer_if.sv
// rtl/maxpool_sequencer_if.sv - pixel, accumulator and pooled-word signals of the maxpool sequencer
interface maxpool_sequencer_if #(
  parameter int OUT_W = 5
);
  logic             iVALID;
  logic             iDATA;
  logic             oREADY;
  logic             oPoolReadEN;
  logic             oPoolWriteEN;
  logic             oPoolDATA;
  logic [6:0]       oPoolADDR;
  logic [OUT_W-1:0] iPoolDATA;
  logic             oVALID;
  logic [OUT_W-1:0] oDATA;
  logic             iREADY;
  logic [6:0]       oROW;

  modport master (
    input  iVALID, iDATA, iPoolDATA, iREADY,
    output oREADY, oPoolReadEN, oPoolWriteEN, oPoolDATA, oPoolADDR,
           oVALID, oDATA, oROW
  );

  modport slave (
    output iVALID, iDATA, iPoolDATA, iREADY,
    input  oREADY, oPoolReadEN, oPoolWriteEN, oPoolDATA, oPoolADDR,
           oVALID, oDATA, oROW
  );
endinterface

// File: rtl/maxpool_sequencer.sv
// rtl/maxpool_sequencer.sv - sequences a binary max-pool accumulator over a raster pixel stream
module maxpool_sequencer #(
  parameter int IN_W = 10,
  parameter int IN_H = 10,
  parameter int POOL = 2
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iSTART,
  output logic oBUSY,
  output logic oDONE,
  maxpool_sequencer_if.master bus
);
  localparam int OUT_W = IN_W / POOL;
  localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int ROW_W = $clog2(IN_H + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} stateT;

  stateT            state;
  stateT            nextState;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [OUT_W-1:0] dataReg;
  logic [6:0]       rowReg;
  logic             doneReg;
  logic             accept;
  logic             lastCol;
  logic             lastRowOfPool;
  logic             lastWord;

  assign lastCol       = (col == COL_W'(IN_W - 1));
  assign lastRowOfPool = ((32'(row) % POOL) == POOL - 1);
  // row has already stepped past the final input row when the last word is shown
  assign lastWord      = (row == ROW_W'(IN_H));

  assign bus.oDATA = dataReg;
  assign bus.oROW  = rowReg;
  assign oDONE     = doneReg;
  assign oBUSY     = (state != IDLE);

  always_comb begin
    nextState        = state;
    accept           = 1'b0;
    bus.oREADY       = 1'b0;
    bus.oPoolReadEN  = 1'b0;
    bus.oPoolWriteEN = 1'b0;
    bus.oPoolDATA    = 1'b0;
    bus.oPoolADDR    = 7'd0;
    bus.oVALID       = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART) nextState = ACCUM;
      end
      ACCUM: begin
        bus.oREADY = 1'b1;
        accept     = bus.iVALID;
        if (accept) begin
          bus.oPoolWriteEN = 1'b1;
          bus.oPoolDATA    = bus.iDATA;
          bus.oPoolADDR    = 7'(32'(col) / POOL);
          if (lastCol && lastRowOfPool) nextState = FLUSH;
        end
      end
      FLUSH: begin
        bus.oPoolReadEN = 1'b1;
        nextState       = OUT;
      end
      OUT: begin
        bus.oVALID = 1'b1;
        if (bus.iREADY) nextState = lastWord ? IDLE : ACCUM;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      dataReg <= '0;
      rowReg  <= 7'd0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            col    <= '0;
            row    <= '0;
            rowReg <= 7'd0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (lastCol) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        // the accumulator clears on this same edge, so capture its row now
        FLUSH: dataReg <= bus.iPoolDATA;
        OUT: begin
          if (bus.iREADY) begin
            if (lastWord) doneReg <= 1'b1;
            else          rowReg  <= rowReg + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_sequencer.sv
// tb/tb_maxpool_sequencer.sv - directed bench for maxpool_sequencer with a binary OR accumulator model
module tb_maxpool_sequencer;
  localparam int IN_W  = 4;
  localparam int IN_H  = 4;
  localparam int POOL  = 2;
  localparam int OUT_W = IN_W / POOL;

  logic iCLK = 1'b0;
  logic iRSTn = 1'b0;
  logic iSTART = 1'b0;
  logic oBUSY;
  logic oDONE;
  logic [OUT_W-1:0] accMem;
  int nChecks = 0;
  int nBad = 0;

  maxpool_sequencer_if #(.OUT_W(OUT_W)) bus ();

  maxpool_sequencer #(.IN_W(IN_W), .IN_H(IN_H), .POOL(POOL)) dut (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iSTART (iSTART),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  // accumulator: OR-in on write, clear on read, shares the reset
  always @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)                accMem <= '0;
    else if (bus.oPoolReadEN)  accMem <= '0;
    else if (bus.oPoolWriteEN) accMem <= accMem | (OUT_W'(bus.oPoolDATA) << bus.oPoolADDR);
  end
  assign bus.iPoolDATA = accMem;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic runFrame(input logic [15:0] pix, input logic [1:0] exp0, input logic [1:0] exp1,
                          input bit toggle, input bit stall, input bit midStart);
    logic [1:0] expWord;
    #1;
    checkVal("idle_busy", oBUSY, 0);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    #1;
    checkVal("start_busy", oBUSY, 1);
    for (int i = 0; i < IN_W * IN_H; i++) begin
      if (toggle && i > 0) begin
        bus.iVALID = 1'b0;
        #1;
        checkVal("gap_wen", bus.oPoolWriteEN, 0);
        checkVal("gap_addr", bus.oPoolADDR, 0);
        @(negedge iCLK);
      end
      bus.iVALID = 1'b1;
      bus.iDATA  = pix[i];
      iSTART     = midStart && (i == 3);
      #1;
      checkVal("acc_rdy", bus.oREADY, 1);
      checkVal("acc_wen", bus.oPoolWriteEN, 1);
      checkVal("acc_ren", bus.oPoolReadEN, 0);
      checkVal("acc_addr", bus.oPoolADDR, (i % IN_W) / POOL);
      checkVal("acc_pdata", bus.oPoolDATA, pix[i]);
      @(negedge iCLK);
      iSTART     = 1'b0;
      bus.iVALID = 1'b0;
      if (i % (IN_W * POOL) == IN_W * POOL - 1) begin
        expWord = (i == IN_W * IN_H - 1) ? exp1 : exp0;
        #1;
        checkVal("flush_ren", bus.oPoolReadEN, 1);
        checkVal("flush_wen", bus.oPoolWriteEN, 0);
        checkVal("flush_rdy", bus.oREADY, 0);
        checkVal("flush_valid", bus.oVALID, 0);
        if (stall) bus.iREADY = 1'b0;
        @(negedge iCLK);
        #1;
        if (stall) begin
          for (int s = 0; s < 5; s++) begin
            checkVal("stall_valid", bus.oVALID, 1);
            checkVal("stall_data", bus.oDATA, expWord);
            checkVal("stall_row", bus.oROW, i / (IN_W * POOL));
            checkVal("stall_rdy", bus.oREADY, 0);
            @(negedge iCLK);
            #1;
          end
        end
        bus.iREADY = 1'b1;
        checkVal("out_valid", bus.oVALID, 1);
        checkVal("out_data", bus.oDATA, expWord);
        checkVal("out_row", bus.oROW, i / (IN_W * POOL));
        checkVal("out_rdy", bus.oREADY, 0);
        @(negedge iCLK);
        #1;
        checkVal("post_valid", bus.oVALID, 0);
        if (i == IN_W * IN_H - 1) begin
          checkVal("done_pulse", oDONE, 1);
          checkVal("done_busy", oBUSY, 0);
          @(negedge iCLK);
          #1;
          checkVal("done_clear", oDONE, 0);
        end else begin
          checkVal("mid_done", oDONE, 0);
          checkVal("mid_busy", oBUSY, 1);
        end
      end
    end
  endtask

  initial begin
    bus.iVALID = 1'b0;
    bus.iDATA  = 1'b0;
    bus.iREADY = 1'b1;
    #1;
    checkVal("rst_busy", oBUSY, 0);
    checkVal("rst_rdy", bus.oREADY, 0);
    checkVal("rst_valid", bus.oVALID, 0);
    checkVal("rst_data", bus.oDATA, 0);
    checkVal("rst_row", bus.oROW, 0);
    checkVal("rst_done", oDONE, 0);
    repeat (2) @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);

    runFrame(16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    runFrame(16'h0080, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    runFrame(16'h0100, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    runFrame(16'hFFFF, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    runFrame(16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    runFrame(16'h1090, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
    runFrame(16'h8421, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);

    // abandon a frame of ones after 6 pixels
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.iVALID = 1'b1;
      bus.iDATA  = 1'b1;
      @(negedge iCLK);
    end
    iRSTn = 1'b0;
    #1;
    checkVal("mrst_busy", oBUSY, 0);
    checkVal("mrst_rdy", bus.oREADY, 0);
    checkVal("mrst_wen", bus.oPoolWriteEN, 0);
    checkVal("mrst_ren", bus.oPoolReadEN, 0);
    checkVal("mrst_pdata", bus.oPoolDATA, 0);
    checkVal("mrst_addr", bus.oPoolADDR, 0);
    checkVal("mrst_valid", bus.oVALID, 0);
    checkVal("mrst_data", bus.oDATA, 0);
    checkVal("mrst_row", bus.oROW, 0);
    checkVal("mrst_done", oDONE, 0);
    bus.iVALID = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);
    #1;
    checkVal("mrst_nodone", oDONE, 0);

    runFrame(16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
